// File: rtl/pwm_timebase.sv
// Up/down/center-aligned PWM timebase with shadowed ARR, mode and repetition count.
// Define PWM_TIMEBASE_REP_CNT_EN to gate update events with the repetition counter.
module pwm_timebase #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned REP_WIDTH = 8
) (
    input  logic                 clk_psc_i,
    input  logic                 rst_n_i,
    input  logic                 ck_cnt_i,
    input  logic                 cnt_en_i,
    input  logic [1:0]           mode_i,
    input  logic [CNT_WIDTH-1:0] arr_preload_i,
    input  logic                 arpe_i,
    input  logic [REP_WIDTH-1:0] rcr_preload_i,
    input  logic                 ug_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 dir_o,
    output logic                 ovf_o,
    output logic                 udf_o,
    output logic                 uev_o,
    output logic [REP_WIDTH-1:0] rep_cnt_o
);

    typedef enum logic [1:0] {
        ModeUp     = 2'b00,
        ModeDown   = 2'b01,
        ModeCenter = 2'b10
    } mode_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] arr_sh_q, arr_sh_d;
    logic                 dir_q, dir_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 uev_q, uev_d;
    mode_e                mode_sh_q, mode_sh_d;
    mode_e                mode_in;
    logic                 rep_zero;

    always_comb begin
        case (mode_i)
            2'b01:   mode_in = ModeDown;
            2'b10:   mode_in = ModeCenter;
            default: mode_in = ModeUp;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        ovf_d     = 1'b0;
        udf_d     = 1'b0;
        uev_d     = 1'b0;
        mode_sh_d = mode_sh_q;
        arr_sh_d  = arpe_i ? arr_sh_q : arr_preload_i;
        if (!cnt_en_i) begin
            cnt_d     = (mode_in == ModeDown) ? arr_preload_i : '0;
            dir_d     = (mode_in == ModeDown);
            mode_sh_d = mode_in;
            arr_sh_d  = arr_preload_i;
        end else begin
            if (ug_i) begin
                cnt_d = (mode_sh_q == ModeDown) ? arr_sh_q : '0;
                dir_d = (mode_sh_q == ModeDown);
            end else if (ck_cnt_i) begin
                case (mode_sh_q)
                    ModeDown: begin
                        if (cnt_q == '0) begin
                            cnt_d = arr_sh_q;
                            udf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CntOne;
                        end
                    end
                    ModeCenter: begin
                        if (!dir_q) begin
                            if (cnt_q >= arr_sh_q) begin
                                ovf_d = 1'b1;
                                dir_d = 1'b1;
                                cnt_d = (arr_sh_q == '0) ? '0 : cnt_q - CntOne;
                            end else begin
                                cnt_d = cnt_q + CntOne;
                            end
                        end else if (cnt_q == '0) begin
                            udf_d = 1'b1;
                            dir_d = 1'b0;
                            cnt_d = (arr_sh_q == '0) ? '0 : CntOne;
                        end else begin
                            cnt_d = cnt_q - CntOne;
                        end
                    end
                    default: begin
                        if (cnt_q >= arr_sh_q) begin
                            cnt_d = '0;
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                endcase
            end
            uev_d = ug_i | ((ovf_d | udf_d) & rep_zero);
            // A new mode only re-derives direction; the count carries on from where it is.
            if (uev_d) begin
                mode_sh_d = mode_in;
                arr_sh_d  = arr_preload_i;
                if (mode_in != mode_sh_q) begin
                    dir_d = (mode_in == ModeDown);
                end
            end
        end
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            uev_q     <= 1'b0;
            arr_sh_q  <= '0;
            mode_sh_q <= ModeUp;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            uev_q     <= uev_d;
            arr_sh_q  <= arr_sh_d;
            mode_sh_q <= mode_sh_d;
        end
    end

`ifdef PWM_TIMEBASE_REP_CNT_EN
    localparam logic [REP_WIDTH-1:0] RepOne = REP_WIDTH'(1);

    logic [REP_WIDTH-1:0] rep_q, rep_d;
    logic [REP_WIDTH-1:0] rcr_sh_q, rcr_sh_d;
    logic                 period_evt;

    assign period_evt = ovf_d | udf_d;
    assign rep_zero   = (rep_q == '0);

    // Reload uses the shadow as it stood before this update event.
    always_comb begin
        rep_d    = rep_q;
        rcr_sh_d = rcr_sh_q;
        if (!cnt_en_i) begin
            rep_d    = rcr_preload_i;
            rcr_sh_d = rcr_preload_i;
        end else if (uev_d) begin
            rep_d    = rcr_sh_q;
            rcr_sh_d = rcr_preload_i;
        end else if (period_evt) begin
            rep_d = rep_q - RepOne;
        end
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rep_q    <= '0;
            rcr_sh_q <= '0;
        end else begin
            rep_q    <= rep_d;
            rcr_sh_q <= rcr_sh_d;
        end
    end

    assign rep_cnt_o = rep_q;
`else
    logic unused_rcr;

    assign unused_rcr = ^rcr_preload_i;
    assign rep_zero   = 1'b1;
    assign rep_cnt_o  = '0;
`endif

    assign cnt_o = cnt_q;
    assign dir_o = dir_q;
    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
    assign uev_o = uev_q;

endmodule

// File: doc/pwm_timebase.md
# pwm_timebase

Multi-mode PWM timebase, the parametrised successor of the single-mode up counter. It counts prescaler ticks in up, down or center-aligned mode against a shadowed auto-reload value, and flags overflow and underflow. It generates a qualified update event (UEV), with an optional repetition counter and a software update request. It sits between the prescaler and the compare/output channels, which consume `cnt_o`, `dir_o` and `uev_o`.

## Interface
- `CNT_WIDTH`, 16, counter and auto-reload width
- `REP_WIDTH`, 8, repetition counter width
- `clk_psc_i` in 1: prescaler clock
- `rst_n_i` in 1: reset, asynchronous, active-low
- `ck_cnt_i` in 1: count tick (clock enable)
- `cnt_en_i` in 1: counter enable
- `mode_i` in 2: 00 up, 01 down, 10 center-aligned, 11 treated as 00
- `arr_preload_i` in CNT_WIDTH: auto-reload preload value
- `arpe_i` in 1: 1 = ARR is buffered until UEV; 0 = ARR shadow tracks preload every cycle
- `rcr_preload_i` in REP_WIDTH: repetition preload value
- `ug_i` in 1: software update generate, single-cycle pulse
- `cnt_o` out CNT_WIDTH: counter value
- `dir_o` out 1: 0 = counting up, 1 = counting down
- `ovf_o` out 1: one-cycle pulse on top wrap / top turnaround
- `udf_o` out 1: one-cycle pulse on bottom wrap / bottom turnaround
- `uev_o` out 1: one-cycle update event pulse
- `rep_cnt_o` out REP_WIDTH: current repetition count

## Operation
- Reset values: `cnt_o`=0, `dir_o`=0, `ovf_o`=`udf_o`=`uev_o`=0, `rep_cnt_o`=0, ARR shadow=0, mode shadow=00, RCR shadow=0.
- Shadows:
  - Mode shadow and RCR shadow load from their inputs on UEV, or every cycle while `cnt_en_i`=0.
  - ARR shadow loads every cycle when `arpe_i`=0 or `cnt_en_i`=0; otherwise only on UEV.
- Disabled (`cnt_en_i`=0): takes priority over everything except reset.
  - `cnt_o` is 0 in up/center mode; `cnt_o`=`arr_preload_i` in down mode.
  - `dir_o` is 1 in down mode, else 0.
  - `rep_cnt_o`=`rcr_preload_i`.
  - All pulses are 0.
- Priority when enabled: `ug_i` > `ck_cnt_i` > hold. With no tick and no `ug_i`, all state holds and all pulses are 0.
- `ug_i`:
  - Counter restarts: 0 and `dir_o`=0 in up/center; ARR shadow value and `dir_o`=1 in down.
  - `uev_o` pulses; `rep_cnt_o` reloads from the RCR shadow.
  - No `ovf_o`/`udf_o` pulse.
- Up mode, per tick:
  - `cnt_o`>=ARR → `cnt_o`=0 and `ovf_o` pulses.
  - Otherwise `cnt_o`+1.
- Down mode, per tick:
  - `cnt_o`==0 → `cnt_o`=ARR and `udf_o` pulses.
  - Otherwise `cnt_o`-1.
- Center mode, per tick:
  - Up phase, `cnt_o`>=ARR → `ovf_o` pulses, `dir_o`=1, `cnt_o`-1 (stays 0 if ARR=0). Otherwise +1.
  - Down phase, `cnt_o`==0 → `udf_o` pulses, `dir_o`=0, `cnt_o`=1 (0 if ARR=0). Otherwise -1.
  - Period is 2×ARR ticks.
- Period event: an `ovf_o` or `udf_o` pulse qualifies for UEV. See Configuration.
- Mode shadow change on UEV takes effect from the next tick. `dir_o` is re-derived as for `ug_i` only when the mode actually changes; the counter does not restart.
- ARR=0: up and down modes hold 0 and pulse every tick.
- Arithmetic is modulo 2^CNT_WIDTH; no other wrap is reachable.

## Timing
- All outputs are registered.
- Pulses assert in the cycle after the edge that sampled the tick or `ug_i`, concurrent with the new `cnt_o`.
- A shadow update on UEV is used by the first compare after the `uev_o` cycle.
- Latency:
  - `ug_i` to `uev_o`: 1 cycle.
  - `cnt_en_i` rise to first count: the first tick sampled while enabled.
- Asynchronous reset mid-count clears all state immediately. Counting resumes on the first tick after release.

## Configuration
- `PWM_TIMEBASE_REP_CNT_EN` defined: repetition counter is active.
  - On a period event: if `rep_cnt_o`==0, `uev_o` pulses and `rep_cnt_o` reloads from the RCR shadow.
  - Otherwise `rep_cnt_o` decrements and there is no UEV.
- Not defined:
  - Every period event produces `uev_o`.
  - `rcr_preload_i` is ignored and `rep_cnt_o` is tied 0.

## Test plan
- Up mode, ARR=3, tick every cycle → `cnt_o` 0,1,2,3,0; `ovf_o` pulses with each return to 0; `uev_o` coincides with `ovf_o` (RCR=0).
- Down mode, ARR=4 → `cnt_o` 4,3,2,1,0,4; `udf_o` pulses with the return to 4; `dir_o`=1 throughout.
- Center mode, ARR=3 → `cnt_o` 0,1,2,3,2,1,0,1; `ovf_o` pulses with 3→2, `udf_o` with 0→1; `dir_o` toggles at each turnaround.
- `arpe_i`=1, ARR 5→2 written mid-period in up mode → count reaches 5 once, then wraps at 2 after the UEV. Repeat with `arpe_i`=0 → wraps at 2 immediately.
- Macro defined, RCR=2, up mode, ARR=1 → `uev_o` on every third `ovf_o`; `rep_cnt_o` sequence 2,1,0,2.
- `ug_i` pulsed at `cnt_o`=2 in up mode, coincident with a tick → next cycle `cnt_o`=0 and `uev_o`=1 with no `ovf_o`. Assert `rst_n_i` mid-count → all outputs 0 immediately.
